// File: rtl/sum_array_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sum_array_pkg
// Description : Shared constants and types for the sum_of_array BRAM
//               sequencer: default address/data widths, BRAM read latency,
//               FSM state encoding and the request-length width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_array_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_DEF = 2;

    // A request length must be able to express a full sweep (2^ADDR_W words),
    // so it needs one bit more than an address.
    function automatic int len_w(input int addr_w);
        return addr_w + 1;
    endfunction

    localparam int LEN_W_DEF = ADDR_W_DEF + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_e;

endpackage : sum_array_pkg
`default_nettype wire

// File: rtl/rd_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_valid_pipe
// Description : DEPTH-deep shift register of read-issue tags. A tag shifted
//               in alongside a BRAM read request emerges on valid_out in the
//               cycle the BRAM presents that request's data.
// Ports       : clk        - clock, posedge
//               rst_n      - synchronous active-low reset, clears all tags
//               tag_in     - 1 when a read request is presented this cycle
//               valid_out  - read data on the BRAM output is valid this cycle
//               empty_next - no tag remains in flight after the coming edge
//                            (valid_out may still be high this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module rd_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tag_in,
    output logic valid_out,
    output logic empty_next
);

    logic [DEPTH-1:0] r_stages;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= tag_in;
                end
            end
            assign empty_next = !tag_in;
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= {r_stages[DEPTH-2:0], tag_in};
                end
            end
            // The last stage is consumed this cycle, so only the input and
            // the younger stages decide whether anything survives the edge.
            assign empty_next = !tag_in && (r_stages[DEPTH-2:0] == '0);
        end
    endgenerate

    assign valid_out = r_stages[DEPTH-1];

endmodule : rd_valid_pipe
`default_nettype wire

// File: rtl/sum_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sum_array_ctrl
// Description : Read sequencer for the sum_of_array BRAM. On an accepted
//               start it issues one read per cycle over a contiguous,
//               wrapping address window, tracks reads through the BRAM read
//               pipeline and accumulates the returned words. A one-cycle
//               done pulse marks a valid sum.
// Build macro : SUM_ARRAY_CTRL_OVF_EN - when defined, ovf is a sticky flag
//               set by any accumulate carry; otherwise ovf is tied to 0.
// Ports       : clk, rst_n            - clock / synchronous active-low reset
//               start, base_addr, len - request, sampled only in IDLE
//               busy, done            - request in progress / completion pulse
//               sum, ovf              - result and sticky carry flag
//               mem_read_en/addr/val  - BRAM read port
// Revision    : 1.0 - initial release
// ============================================================================
module sum_array_ctrl
    import sum_array_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic              ovf,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_val
);

    localparam int LEN_W = len_w(ADDR_W);
    localparam logic [LEN_W-1:0] C_ONE = LEN_W'(1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_sum;
    logic              w_accept;
    logic              w_valid;
    logic              w_empty_next;

    assign w_accept = (r_state == IDLE) && start;

    // The tag enters with the registered read enable, i.e. in step with the
    // BRAM's own sampling of read_en.
    rd_valid_pipe #(
        .DEPTH (RD_LAT)
    ) u_valid_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_in     (r_en),
        .valid_out  (w_valid),
        .empty_next (w_empty_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= len;
                        r_cnt  <= '0;
                        // An empty request spends one cycle in DRAIN (where
                        // the pipe is already empty) so done lands one cycle
                        // after the accept edge.
                        r_state <= (len != '0) ? ISSUE : DRAIN;
                    end
                end
                ISSUE: begin
                    r_en   <= 1'b1;
                    r_addr <= r_base + r_cnt[ADDR_W-1:0];
                    r_cnt  <= r_cnt + C_ONE;
                    if ((r_cnt + C_ONE) == r_len) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty_next) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SUM_ARRAY_CTRL_OVF_EN
    logic              r_ovf;
    logic [DATA_W:0]   w_acc;

    assign w_acc = {1'b0, r_sum} + {1'b0, mem_read_val};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else if (w_valid) begin
            r_sum <= w_acc[DATA_W-1:0];
            r_ovf <= r_ovf | w_acc[DATA_W];
        end
    end

    assign ovf = r_ovf;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_valid) begin
            r_sum <= r_sum + mem_read_val;
        end
    end

    assign ovf = 1'b0;
`endif

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign sum           = r_sum;
    assign mem_read_en   = r_en;
    assign mem_read_addr = r_addr;

endmodule : sum_array_ctrl
`default_nettype wire

// File: tb/tb_sum_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_array_ctrl
// Description : Self-checking bench for sum_array_ctrl with a 2-stage
//               registered BRAM model. A transaction-level model turns each
//               accepted request into per-cycle expectations (busy, read
//               enable/address, done, sum, ovf) that are compared every cycle;
//               directed tests pin the model with hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_array_ctrl;

    localparam int LAT  = 2;
    localparam int MAXC = 4096;
`ifdef SUM_ARRAY_CTRL_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        busy, done, ovf, mem_read_en;
    logic [31:0] sum, mem_read_val;
    logic [9:0]  mem_read_addr;

    always #5 clk = ~clk;

    sum_array_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .len           (len),
        .busy          (busy),
        .done          (done),
        .sum           (sum),
        .ovf           (ovf),
        .mem_read_en   (mem_read_en),
        .mem_read_addr (mem_read_addr),
        .mem_read_val  (mem_read_val)
    );

    // BRAM: read_en/addr sampled at an edge, data two registers later.
    // Output holds stale data when no read is in flight.
    logic [31:0] ram [0:1023];
    logic [31:0] s1 = 32'h5A5A_5A5A;
    logic [31:0] s2 = 32'hA5A5_A5A5;
    always @(posedge clk) begin
        if (mem_read_en) s1 <= ram[mem_read_addr];
        s2 <= s1;
    end
    assign mem_read_val = s2;

    // ---------------- model ----------------
    int cyc = 0;
    int idle_from = 0;
    int nvec = 0;
    int nfail = 0;
    bit chk_on = 1'b0;
    bit          m_busy [MAXC];
    bit          m_en   [MAXC];
    bit          m_done [MAXC];
    bit          m_ovf  [MAXC];
    logic [9:0]  m_addr [MAXC];
    logic [31:0] m_sum  [MAXC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_accept(input int a, input logic [9:0] b, input logic [10:0] n);
        longint total = 0;
        int d;
        d = (n == 0) ? a + 1 : a + int'(n) + LAT + 1;
        if (d + 2 >= MAXC) begin
            $display("FAIL model_range @cycle %0d: got %0d, want < %0d", a, d, MAXC);
            $fatal(1);
        end
        for (int i = 0; i < int'(n); i++) begin
            m_en[a + 1 + i]   = 1'b1;
            m_addr[a + 1 + i] = 10'(int'(b) + i);
            total += longint'(ram[(int'(b) + i) % 1024]);
        end
        for (int c = a; c <= d; c++) m_busy[c] = 1'b1;
        m_done[d] = 1'b1;
        m_sum[d]  = total[31:0];
        m_ovf[d]  = OVF_ON && (total > 64'h0000_0000_FFFF_FFFF);
        idle_from = d + 2;
    endfunction

    // Edge-level model: reset discards everything not yet seen, a start is
    // honoured only once the previous request has returned to idle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            for (int c = cyc; c < MAXC; c++) begin
                m_busy[c] = 1'b0; m_en[c] = 1'b0; m_done[c] = 1'b0; m_ovf[c] = 1'b0;
            end
            idle_from = cyc + 1;
            chk_on    = 1'b1;
        end else if (start && cyc >= idle_from) begin
            model_accept(cyc, base_addr, len);
        end
    end

    always @(negedge clk) begin
        if (chk_on && cyc < MAXC) begin
            chk("busy", busy, m_busy[cyc]);
            chk("rd_en", mem_read_en, m_en[cyc]);
            chk("done", done, m_done[cyc]);
            if (m_en[cyc]) chk("rd_addr", mem_read_addr, m_addr[cyc]);
            if (m_done[cyc]) begin
                chk("sum", sum, m_sum[cyc]);
                chk("ovf", ovf, m_ovf[cyc]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [9:0] b, input logic [10:0] n, output int a);
        base_addr = b;
        len       = n;
        start     = 1'b1;
        tick();
        start = 1'b0;
        a = cyc;
    endtask

    task automatic wait_done(input int lim, output int at);
        int k = 0;
        while (done !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
        if (done !== 1'b1) begin
            nvec++;
            nfail++;
            $display("FAIL done_timeout @cycle %0d: got no done, want done within %0d cycles", cyc, lim);
        end
        at = cyc;
    endtask

    int a, a2, at, dummy;

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'(i * 3 + 100);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_addr", mem_read_addr, 0);
        chk("rst_ovf", ovf, 0);

        // basic window
        ram[0] = 1; ram[1] = 2; ram[2] = 3; ram[3] = 4;
        go(10'd0, 11'd4, a);
        wait_done(50, at);
        chk("t1_sum", sum, 10);
        chk("t1_lat", at - a, 7);
        tick(2);

        // wrapping window
        ram[1022] = 5; ram[1023] = 6; ram[0] = 7; ram[1] = 8;
        go(10'd1022, 11'd4, a);
        wait_done(50, at);
        chk("t2_sum", sum, 26);
        tick(2);

        // empty request
        go(10'd5, 11'd0, a);
        wait_done(10, at);
        chk("t3_sum", sum, 0);
        chk("t3_lat", at - a, 1);
        tick(2);

        // start while busy is ignored
        ram[0] = 1; ram[1] = 2; ram[2] = 3; ram[3] = 4;
        go(10'd0, 11'd4, a);
        tick(2);
        go(10'd1, 11'd3, dummy);
        wait_done(50, at);
        chk("t4_sum", sum, 10);
        chk("t4_lat", at - a, 7);
        tick(10);

        // reset during ISSUE
        for (int i = 0; i < 8; i++) ram[i] = 32'(10 + i);
        go(10'd0, 11'd8, a);
        tick(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_en", mem_read_en, 0);
        chk("t5_sum", sum, 0);
        chk("t5_addr", mem_read_addr, 0);
        tick(15);
        ram[0] = 1; ram[1] = 2;
        go(10'd0, 11'd2, a);
        wait_done(50, at);
        chk("t5b_sum", sum, 3);
        tick(2);

        // carry out of the accumulator
        ram[0] = 32'hFFFF_FFFF; ram[1] = 32'hFFFF_FFFF;
        go(10'd0, 11'd2, a);
        wait_done(50, at);
        chk("t6_sum", sum, 64'hFFFF_FFFE);
        chk("t6_ovf", ovf, OVF_ON);
        tick(2);

        // start held from the done cycle: accepted one cycle later
        ram[2] = 55; ram[3] = 77;
        go(10'd3, 11'd1, a);
        wait_done(50, at);
        chk("t7a_sum", sum, 77);
        base_addr = 10'd2;
        len       = 11'd1;
        start     = 1'b1;
        tick();
        chk("t7_not_in_done", busy, 0);
        tick();
        start = 1'b0;
        a2 = cyc;
        chk("t7_accept_busy", busy, 1);
        wait_done(50, at);
        chk("t7b_sum", sum, 55);
        chk("t7b_lat", at - a2, 4);
        tick(2);

        // full-memory sweep from the middle
        for (int i = 0; i < 1024; i++) ram[i] = 32'(i);
        go(10'd512, 11'd1024, a);
        wait_done(1100, at);
        chk("t8_sum", sum, 523776);
        chk("t8_lat", at - a, 1027);
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule : tb_sum_array_ctrl
`default_nettype wire
